stage_display_responder: RTL and testbench
==========================================

// Module: stage_display_responder
// PURPOSE
//  Datapath-side responder to the game-flow controller FSM. Decodes its one-hot state levels and runs each job:
//  draw start/begin/clear screens and towers via a VGA pixel port, and count car kills/escapes.
//  Returns the matching one-cycle done pulses, plus the game-over level. Sits between the controller and vga_adapter.
// PARAMETERS
//  SCREEN_W        160  screen/image width in pixels
//  SCREEN_H        120  screen/image height in pixels
//  TOWER_SIZE      16   tower sprite edge (square), pixels
//  CARS_PER_STAGE  10   kills needed to clear a stage
//  LIVES           3    escapes tolerated before game over
//  COLOUR_W        3    colour bits per pixel
// PORTS
//  clk                 in   1         system clock
//  resetn              in   1         asynchronous, active-low reset
//  wait_start          in   1         controller level: start screen
//  start_key           in   1         player start (synchronised, level)
//  stage_begin         in   3         level per stage [0]=stage 1
//  stage_draw_tower    in   3         level per stage
//  stage_in_progress   in   3         level per stage
//  stage_done          in   3         level per stage (clear screen)
//  car_killed          in   1         1-cycle pulse per destroyed car
//  car_escaped         in   1         1-cycle pulse per escaped car
//  img_sel             out  4         ROM image: 0 START,1-3 BEGIN_n,4-6 END_n,7 TOWER
//  rom_addr            out  15        pixel index within image, y*W+x
//  rom_q               in   COLOUR_W  ROM data, 1-cycle read latency
//  x / y               out  8 / 7     VGA pixel coordinate
//  colour              out  COLOUR_W  VGA pixel colour
//  plot                out  1         VGA write enable
//  start_display_done  out  1         pulse
//  stage_begin_done    out  3         pulse per stage
//  stage_tower_done    out  3         pulse per stage
//  stage_car_done      out  3         pulse per stage
//  stage_end_display_done out 3       pulse per stage
//  game_over           out  1         level
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, lives=LIVES, FSM IDLE; async assert, sync release.
//  Requests are levels; a job starts only on a rising edge (registered previous request). Inputs are one-hot.
//  Simultaneous edges take fixed priority: wait_start > begin > tower > done; lowest stage index wins.
//  FSM: IDLE -> SCAN (draw) -> FLUSH (1 cycle, last ROM word) -> [WAIT_KEY if start job] -> PULSE -> IDLE.
//  SCAN: raster x then y from 0. rom_addr=(y<<7)+(y<<5)+x for 160-wide screens, y*TOWER_SIZE+x for the tower.
//  x/y/colour/plot are registered one cycle behind rom_addr, aligned to rom_q.
//  Full screen: plot high exactly SCREEN_W*SCREEN_H consecutive cycles. Tower: TOWER_SIZE^2.
//  Tower origin (x0,y0) comes per stage from the package; x=x0+col, y=y0+row.
//  WAIT_KEY: hold plot 0 until start_key=1, then PULSE.
//  PULSE: matching done bit high exactly 1 cycle. Controller leaves the state next cycle; no re-trigger since level falls.
//  Abort: request level falls before PULSE -> plot 0, return IDLE next cycle, no done pulse.
//  Game play: kill counter cleared on every stage_begin edge. car_killed increments only while stage_in_progress[n].
//  When kills reach CARS_PER_STAGE: stage_car_done[n] pulses 1 cycle, counter saturates (no further pulse).
//  car_escaped during in_progress decrements lives (floor 0). game_over = (lives==0), held until wait_start edge or reset.
//  Kill+escape in same cycle: both counted. If car_done and game_over assert together, both are driven; controller priority decides.
//  Pulses outside any in_progress level are ignored.
// STRUCTURE
//  Package game_pkg: state localparams, IMG_* select codes, TOWER_X0/Y0[1:3], SCREEN_W/H defaults.
//  Sub-module: raster_scanner (x/y counters, rom_addr, 1-cycle aligned plot pipeline, last-pixel flag).
//  Top holds edge detect, job FSM, kill/lives counters.
// TESTING
//  Reset mid-SCAN (resetn=0 at pixel 500): plot=0 same cycle; all pulses 0; lives=3 after release.
//  wait_start rise, start_key=0: 19200 plot cycles, img_sel=0. Then start_key=1 -> start_display_done 1 cycle.
//  stage_draw_tower[1] rise (x0=40,y0=50): 256 plots, last at (55,65), rom_addr 255. Then stage_tower_done[1] pulse.
//  stage_in_progress[0] + 10 car_killed -> stage_car_done[0] 1 cycle; 11th kill gives no pulse.
//  3 car_escaped -> game_over=1 after 3rd. Kill #10 with escape #3 in same cycle -> car_done and game_over both high.
//  stage_done[2] dropped at pixel 100 -> plot 0 next cycle, no end_display_done; stage_begin[0]+stage_done[2] same edge -> begin job runs.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the stage display responder and its raster scanner.
package game_pkg;

    localparam int SCREEN_W_DEF       = 160;
    localparam int SCREEN_H_DEF       = 120;
    localparam int TOWER_SIZE_DEF     = 16;
    localparam int CARS_PER_STAGE_DEF = 10;
    localparam int LIVES_DEF          = 3;
    localparam int COLOUR_W_DEF       = 3;

    localparam logic [3:0] IMG_START   = 4'd0;
    localparam logic [3:0] IMG_BEGIN_1 = 4'd1;
    localparam logic [3:0] IMG_END_1   = 4'd4;
    localparam logic [3:0] IMG_TOWER   = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH,
        ST_WAIT_KEY,
        ST_PULSE
    } state_e;

    typedef enum logic [1:0] {
        JOB_START,
        JOB_BEGIN,
        JOB_TOWER,
        JOB_END
    } job_e;

    // Tower origin for stage index 0..2 (stages 1..3).
    function automatic logic [7:0] tower_x0(input logic [1:0] stage);
        case (stage)
            2'd0:    tower_x0 = 8'd20;
            2'd1:    tower_x0 = 8'd40;
            default: tower_x0 = 8'd100;
        endcase
    endfunction

    function automatic logic [6:0] tower_y0(input logic [1:0] stage);
        case (stage)
            2'd0:    tower_y0 = 7'd30;
            2'd1:    tower_y0 = 7'd50;
            default: tower_y0 = 7'd80;
        endcase
    endfunction

    function automatic logic [1:0] lowest_set(input logic [2:0] v);
        if (v[0])      lowest_set = 2'd0;
        else if (v[1]) lowest_set = 2'd1;
        else           lowest_set = 2'd2;
    endfunction

endpackage

// File: rtl/raster_scanner.sv
// Raster walk over a full screen or a tower sprite: ROM address now, pixel
// coordinate and plot one cycle later so they line up with the ROM data.
module raster_scanner
    import game_pkg::*;
#(
    parameter int SCREEN_W   = SCREEN_W_DEF,
    parameter int SCREEN_H   = SCREEN_H_DEF,
    parameter int TOWER_SIZE = TOWER_SIZE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        step,
    input  logic        tower,
    input  logic [7:0]  x0,
    input  logic [6:0]  y0,
    output logic [14:0] rom_addr,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic        plot,
    output logic        last
);

    logic [7:0] col;
    logic [6:0] row;
    logic [7:0] col_max;
    logic [6:0] row_max;
    logic       last_col;

    assign col_max  = tower ? 8'(TOWER_SIZE - 1) : 8'(SCREEN_W - 1);
    assign row_max  = tower ? 7'(TOWER_SIZE - 1) : 7'(SCREEN_H - 1);
    assign last_col = (col == col_max);
    assign last     = last_col && (row == row_max);

    // y*160 folds into two shifts; other widths fall back to a constant multiply.
    always_comb begin
        if (tower)
            rom_addr = 15'(row) * 15'(TOWER_SIZE) + 15'(col);
        else if (SCREEN_W == 160)
            rom_addr = (15'(row) << 7) + (15'(row) << 5) + 15'(col);
        else
            rom_addr = 15'(row) * 15'(SCREEN_W) + 15'(col);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            x    <= '0;
            y    <= '0;
            plot <= 1'b0;
        end else begin
            plot <= step;
            if (step) begin
                x <= x0 + col;
                y <= y0 + row;
            end
            if (clear || (step && last)) begin
                col <= '0;
                row <= '0;
            end else if (step) begin
                if (last_col) begin
                    col <= '0;
                    row <= row + 7'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/stage_display_responder.sv
// Runs the draw and scoring jobs requested by the game-flow controller and
// answers each with a one-cycle done pulse.
//   state    | meaning
//   IDLE     | waiting for a request rising edge
//   SCAN     | issuing ROM addresses, one pixel per cycle
//   FLUSH    | last ROM word returns and is plotted
//   WAIT_KEY | start screen drawn, waiting for the player
//   PULSE    | done bit of the finished job high for one cycle
module stage_display_responder
    import game_pkg::*;
#(
    parameter int SCREEN_W       = SCREEN_W_DEF,
    parameter int SCREEN_H       = SCREEN_H_DEF,
    parameter int TOWER_SIZE     = TOWER_SIZE_DEF,
    parameter int CARS_PER_STAGE = CARS_PER_STAGE_DEF,
    parameter int LIVES          = LIVES_DEF,
    parameter int COLOUR_W       = COLOUR_W_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wait_start,
    input  logic                start_key,
    input  logic [2:0]          stage_begin,
    input  logic [2:0]          stage_draw_tower,
    input  logic [2:0]          stage_in_progress,
    input  logic [2:0]          stage_done,
    input  logic                car_killed,
    input  logic                car_escaped,
    output logic [3:0]          img_sel,
    output logic [14:0]         rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                start_display_done,
    output logic [2:0]          stage_begin_done,
    output logic [2:0]          stage_tower_done,
    output logic [2:0]          stage_car_done,
    output logic [2:0]          stage_end_display_done,
    output logic                game_over
);

    localparam int KW = $clog2(CARS_PER_STAGE + 1);
    localparam int LW = $clog2(LIVES + 1);

    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rst_pipe <= 2'b00;
        else         rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    logic       ws_q;
    logic [2:0] sb_q, st_q, sd_q;
    logic       ws_rise;
    logic [2:0] sb_rise, st_rise, sd_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_q <= 1'b0;
            sb_q <= '0;
            st_q <= '0;
            sd_q <= '0;
        end else begin
            ws_q <= wait_start;
            sb_q <= stage_begin;
            st_q <= stage_draw_tower;
            sd_q <= stage_done;
        end
    end

    assign ws_rise = wait_start & ~ws_q;
    assign sb_rise = stage_begin & ~sb_q;
    assign st_rise = stage_draw_tower & ~st_q;
    assign sd_rise = stage_done & ~sd_q;

    state_e     state_q, state_d;
    job_e       job_q, job_d;
    logic [1:0] stage_q, stage_d;
    logic [3:0] img_q, img_d;
    logic       req_lvl, pulse;
    logic       scan_clear, scan_step, scan_last;
    logic [2:0] stage_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            job_q   <= JOB_START;
            stage_q <= '0;
            img_q   <= IMG_START;
        end else begin
            state_q <= state_d;
            job_q   <= job_d;
            stage_q <= stage_d;
            img_q   <= img_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        job_d      = job_q;
        stage_d    = stage_q;
        img_d      = img_q;
        scan_clear = 1'b0;
        scan_step  = 1'b0;
        case (job_q)
            JOB_START: req_lvl = wait_start;
            JOB_BEGIN: req_lvl = stage_begin[stage_q];
            JOB_TOWER: req_lvl = stage_draw_tower[stage_q];
            default:   req_lvl = stage_done[stage_q];
        endcase
        case (state_q)
            ST_IDLE: begin
                scan_clear = 1'b1;
                if (ws_rise) begin
                    job_d   = JOB_START;
                    stage_d = 2'd0;
                    img_d   = IMG_START;
                    state_d = ST_SCAN;
                end else if (|sb_rise) begin
                    job_d   = JOB_BEGIN;
                    stage_d = lowest_set(sb_rise);
                    img_d   = IMG_BEGIN_1 + {2'b00, lowest_set(sb_rise)};
                    state_d = ST_SCAN;
                end else if (|st_rise) begin
                    job_d   = JOB_TOWER;
                    stage_d = lowest_set(st_rise);
                    img_d   = IMG_TOWER;
                    state_d = ST_SCAN;
                end else if (|sd_rise) begin
                    job_d   = JOB_END;
                    stage_d = lowest_set(sd_rise);
                    img_d   = IMG_END_1 + {2'b00, lowest_set(sd_rise)};
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!req_lvl) begin
                    state_d = ST_IDLE;
                end else begin
                    scan_step = 1'b1;
                    if (scan_last) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!req_lvl)                state_d = ST_IDLE;
                else if (job_q == JOB_START) state_d = ST_WAIT_KEY;
                else                         state_d = ST_PULSE;
            end
            ST_WAIT_KEY: begin
                if (!req_lvl)       state_d = ST_IDLE;
                else if (start_key) state_d = ST_PULSE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pulse     = (state_q == ST_PULSE);
    assign stage_bit = 3'b001 << stage_q;

    assign start_display_done     = pulse && (job_q == JOB_START);
    assign stage_begin_done       = (pulse && job_q == JOB_BEGIN) ? stage_bit : 3'b000;
    assign stage_tower_done       = (pulse && job_q == JOB_TOWER) ? stage_bit : 3'b000;
    assign stage_end_display_done = (pulse && job_q == JOB_END)   ? stage_bit : 3'b000;
    assign img_sel                = img_q;
    assign colour                 = plot ? rom_q : '0;

    raster_scanner #(
        .SCREEN_W   (SCREEN_W),
        .SCREEN_H   (SCREEN_H),
        .TOWER_SIZE (TOWER_SIZE)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (scan_clear),
        .step     (scan_step),
        .tower    (job_q == JOB_TOWER),
        .x0       ((job_q == JOB_TOWER) ? tower_x0(stage_q) : 8'd0),
        .y0       ((job_q == JOB_TOWER) ? tower_y0(stage_q) : 7'd0),
        .rom_addr (rom_addr),
        .x        (x),
        .y        (y),
        .plot     (plot),
        .last     (scan_last)
    );

    logic [KW-1:0] kills_q;
    logic [LW-1:0] lives_q;
    logic [2:0]    car_done_q;
    logic          in_prog, kill_ok, kill_hit;

    assign in_prog  = |stage_in_progress;
    assign kill_ok  = car_killed && in_prog && (kills_q != KW'(CARS_PER_STAGE));
    assign kill_hit = kill_ok && (kills_q == KW'(CARS_PER_STAGE - 1));

    // The done pulse follows the kill by one cycle, the same cycle lives drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kills_q    <= '0;
            lives_q    <= LW'(LIVES);
            car_done_q <= '0;
        end else begin
            car_done_q <= kill_hit ? stage_in_progress : 3'b000;
            if (|sb_rise)     kills_q <= '0;
            else if (kill_ok) kills_q <= kills_q + KW'(1);
            if (ws_rise)
                lives_q <= LW'(LIVES);
            else if (car_escaped && in_prog && lives_q != '0)
                lives_q <= lives_q - LW'(1);
        end
    end

    assign stage_car_done = car_done_q;
    assign game_over      = (lives_q == '0);

endmodule

// File: tb/tb_stage_display_responder.sv
// Scoreboard bench: stimulus queues expected pixels/pulses, a negedge monitor
// pops one entry for every plot or done pulse the responder presents.
module tb_stage_display_responder;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wait_start = 1'b0, start_key = 1'b0;
    logic [2:0]  stage_begin = '0, stage_draw_tower = '0, stage_in_progress = '0, stage_done = '0;
    logic        car_killed = 1'b0, car_escaped = 1'b0;
    logic [3:0]  img_sel;
    logic [14:0] rom_addr;
    logic [2:0]  rom_q = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        start_display_done;
    logic [2:0]  stage_begin_done, stage_tower_done, stage_car_done, stage_end_display_done;
    logic        game_over;

    always #5 clk = ~clk;

    stage_display_responder dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .wait_start             (wait_start),
        .start_key              (start_key),
        .stage_begin            (stage_begin),
        .stage_draw_tower       (stage_draw_tower),
        .stage_in_progress      (stage_in_progress),
        .stage_done             (stage_done),
        .car_killed             (car_killed),
        .car_escaped            (car_escaped),
        .img_sel                (img_sel),
        .rom_addr               (rom_addr),
        .rom_q                  (rom_q),
        .x                      (x),
        .y                      (y),
        .colour                 (colour),
        .plot                   (plot),
        .start_display_done     (start_display_done),
        .stage_begin_done       (stage_begin_done),
        .stage_tower_done       (stage_tower_done),
        .stage_car_done         (stage_car_done),
        .stage_end_display_done (stage_end_display_done),
        .game_over              (game_over)
    );

    function automatic logic [2:0] rom_fn(input int addr, input int img);
        logic [14:0] a;
        logic [3:0]  i;
        a = 15'(addr);
        i = 4'(img);
        return a[2:0] ^ a[5:3] ^ i[2:0];
    endfunction

    // One-cycle-latency ROM; addr_d remembers which address produced rom_q.
    logic [14:0] addr_d = '0;
    always @(posedge clk) begin
        addr_d <= rom_addr;
        rom_q  <= rom_fn(int'(rom_addr), int'(img_sel));
    end

    typedef struct {
        bit          is_pulse;
        int          x;
        int          y;
        int          addr;
        int          img;
        logic [12:0] pul;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  fails  = 0;
    int  events = 0;

    logic [12:0] pul_now;
    assign pul_now = {start_display_done, stage_begin_done, stage_tower_done,
                      stage_car_done, stage_end_display_done};

    always @(negedge clk) begin : monitor
        ev_t e;
        if (plot) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d addr=%0d, want no plot", x, y, addr_d);
            end else begin
                e = exp_q.pop_front();
                if (e.is_pulse || int'(x) != e.x || int'(y) != e.y || int'(addr_d) != e.addr ||
                    colour != rom_fn(e.addr, e.img) || int'(img_sel) != e.img) begin
                    fails++;
                    $display("FAIL pixel_%0d: got x=%0d y=%0d addr=%0d col=%0d img=%0d, want x=%0d y=%0d addr=%0d col=%0d img=%0d pulse_expected=%0d",
                             events, x, y, addr_d, colour, img_sel, e.x, e.y, e.addr,
                             rom_fn(e.addr, e.img), e.img, e.is_pulse);
                end
            end
            events++;
        end
        if (pul_now != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got %b, want none", pul_now);
            end else begin
                e = exp_q.pop_front();
                if (!e.is_pulse || pul_now != e.pul) begin
                    fails++;
                    $display("FAIL done_pulse: got %b, want %b (pulse_expected=%0d)", pul_now, e.pul, e.is_pulse);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic push_screen(input int img, input int n);
        ev_t e;
        for (int i = 0; i < n; i++) begin
            e.is_pulse = 1'b0;
            e.x = i % 160;
            e.y = i / 160;
            e.addr = i;
            e.img = img;
            e.pul = '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_tower(input int x0, input int y0);
        ev_t e;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                e.is_pulse = 1'b0;
                e.x = x0 + c;
                e.y = y0 + r;
                e.addr = r * 16 + c;
                e.img = 7;
                e.pul = '0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_pulse(input logic [12:0] bits);
        ev_t e;
        e.is_pulse = 1'b1;
        e.x = 0;
        e.y = 0;
        e.addr = 0;
        e.img = 0;
        e.pul = bits;
        exp_q.push_back(e);
    endtask

    task automatic wait_left(input int left, input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() > left && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() > left) begin
            fails++;
            $display("FAIL %s: got %0d events pending, want %0d", name, exp_q.size(), left);
            if (left == 0) exp_q.delete();
        end
    endtask

    task automatic pulse_car(input logic k, input logic e);
        car_killed  = k;
        car_escaped = e;
        tick(1);
        car_killed  = 1'b0;
        car_escaped = 1'b0;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("rst_plot", int'(plot), 0);
        check("rst_pulses", int'(pul_now), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_img_sel", int'(img_sel), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);
        resetn = 1'b1;
        tick(4);

        // Start screen, then hold in WAIT_KEY until the key arrives.
        push_screen(0, 19200);
        wait_start = 1'b1;
        wait_left(0, 19300, "start_screen");
        tick(6);
        push_pulse(13'h1000);
        start_key = 1'b1;
        wait_left(0, 6, "start_done");
        wait_start = 1'b0;
        start_key  = 1'b0;
        tick(3);

        // Tower for stage 2 at (40,50).
        push_tower(40, 50);
        push_pulse(13'h0080);
        stage_draw_tower = 3'b010;
        wait_left(0, 300, "tower_stage2");
        stage_draw_tower = 3'b000;
        tick(3);

        // End screen 3 aborted after its 100th plotted pixel.
        push_screen(6, 101);
        stage_done = 3'b100;
        wait_left(1, 200, "end3_partial");
        stage_done = 3'b000;
        wait_left(0, 5, "end3_abort");
        tick(6);

        // Begin 1 and end 3 on the same edge: begin wins.
        push_screen(1, 19200);
        push_pulse(13'h0200);
        stage_begin = 3'b001;
        stage_done  = 3'b100;
        wait_left(0, 19300, "begin1_priority");
        stage_begin = 3'b000;
        stage_done  = 3'b000;
        tick(3);

        // Car events outside any in-progress level are ignored.
        repeat (3) pulse_car(1'b1, 1'b0);
        pulse_car(1'b0, 1'b1);
        check("go_idle_events", int'(game_over), 0);

        stage_in_progress = 3'b001;
        for (int i = 0; i < 9; i++) pulse_car(1'b1, (i == 2 || i == 5));
        check("go_after_2_escapes", int'(game_over), 0);
        push_pulse(13'h0008);
        pulse_car(1'b1, 1'b0);
        wait_left(0, 4, "car_done_stage1");
        pulse_car(1'b1, 1'b0);
        tick(3);
        stage_in_progress = 3'b000;
        tick(1);

        // Stage 2 begin edge clears kills; the draw job is dropped immediately.
        stage_begin = 3'b010;
        tick(1);
        stage_begin = 3'b000;
        tick(3);
        stage_in_progress = 3'b010;
        repeat (9) pulse_car(1'b1, 1'b0);
        check("go_before_3rd_escape", int'(game_over), 0);
        push_pulse(13'h0010);
        car_killed  = 1'b1;
        car_escaped = 1'b1;
        tick(1);
        car_killed  = 1'b0;
        car_escaped = 1'b0;
        check("car_done_with_go", int'(stage_car_done), 2);
        check("go_with_car_done", int'(game_over), 1);
        tick(1);
        wait_left(0, 3, "car_done_stage2");
        pulse_car(1'b0, 1'b1);
        stage_in_progress = 3'b000;
        tick(5);
        check("go_held", int'(game_over), 1);

        wait_start = 1'b1;
        tick(1);
        wait_start = 1'b0;
        tick(3);
        check("go_cleared_by_start", int'(game_over), 0);

        // Reset while the end-1 screen is mid-scan.
        push_screen(4, 500);
        stage_done = 3'b001;
        wait_left(0, 700, "end1_before_reset");
        check("plot_before_reset", int'(plot), 1);
        resetn = 1'b0;
        #1;
        check("plot_in_reset", int'(plot), 0);
        check("pulses_in_reset", int'(pul_now), 0);
        check("rom_addr_in_reset", int'(rom_addr), 0);
        stage_done = 3'b000;
        tick(2);
        resetn = 1'b1;
        tick(4);

        stage_in_progress = 3'b100;
        pulse_car(1'b0, 1'b1);
        pulse_car(1'b0, 1'b1);
        check("lives_after_reset_2esc", int'(game_over), 0);
        pulse_car(1'b0, 1'b1);
        check("lives_after_reset_3esc", int'(game_over), 1);
        stage_in_progress = 3'b000;
        tick(3);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
